// File: rtl/rr_mux_arb.sv
// rr_mux_arb: N-channel, W-bit arbitrating multiplexer with one registered
// output stage. Arbitration is round-robin (mode_i=0) or fixed priority,
// lowest index first (mode_i=1).
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   [N]    per-channel valid
//   in_data_i    [N*W]  channel k data in bits [k*W +: W]
//   in_ready_o   [N]    one-hot grant / accept (zero while in reset)
//   mode_i              0 = round-robin, 1 = fixed priority
//   out_valid_o         output register holds a beat
//   out_data_o   [W]    registered data of the granted channel
//   out_sel_o    [SW]   index of the channel that supplied out_data_o
//   out_ready_i         downstream accept
//   in_last_i    [N]    end-of-packet marker (only with RR_MUX_LOCK_EN)
//
// Build option RR_MUX_LOCK_EN: adds in_last_i. Once a channel transfers a
// beat without in_last, the arbiter stays locked to it until the beat with
// in_last has been transferred; the pointer advances only on that beat.
module rr_mux_arb #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [N-1:0]   in_valid_i,
  input  logic [N*W-1:0] in_data_i,
  output logic [N-1:0]   in_ready_o,
  input  logic           mode_i,
`ifdef RR_MUX_LOCK_EN
  input  logic [N-1:0]   in_last_i,
`endif
  output logic           out_valid_o,
  output logic [W-1:0]   out_data_o,
  output logic [SW-1:0]  out_sel_o,
  input  logic           out_ready_i
);

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_sel_q, out_sel_d;
  logic [SW-1:0] ptr_q, ptr_d;
`ifdef RR_MUX_LOCK_EN
  logic          lock_q, lock_d;
  logic [SW-1:0] lock_ch_q, lock_ch_d;
`endif

  logic          load;
  logic          gnt_vld;
  logic [SW-1:0] gnt_idx;
  logic [SW-1:0] ptr_inc;
  logic [SW:0]   rr_sum;
  logic [SW-1:0] rr_idx;

  assign load = !out_valid_q || out_ready_i;

  // Grant selection. The round-robin search index is ptr+i folded back
  // into 0..N-1 so that non-power-of-two N wraps correctly.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_sum  = '0;
    rr_idx  = '0;
    if (mode_i) begin
      for (int i = 0; i < N; i++) begin
        if (!gnt_vld && in_valid_i[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = SW'(i);
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        rr_sum = {1'b0, ptr_q} + (SW+1)'(i);
        if (rr_sum >= (SW+1)'(N)) rr_sum = rr_sum - (SW+1)'(N);
        rr_idx = rr_sum[SW-1:0];
        if (!gnt_vld && in_valid_i[rr_idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = rr_idx;
        end
      end
    end
`ifdef RR_MUX_LOCK_EN
    // A packet in progress overrides both arbitration modes.
    if (lock_q) begin
      gnt_vld = in_valid_i[lock_ch_q];
      gnt_idx = lock_ch_q;
    end
`endif
  end

  assign ptr_inc = (gnt_idx == SW'(N-1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    in_ready_o = '0;
    if (rst_ni && load && gnt_vld) in_ready_o[gnt_idx] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
`ifdef RR_MUX_LOCK_EN
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
`endif
    if (load) begin
      if (gnt_vld) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data_i[gnt_idx*W +: W];
        out_sel_d   = gnt_idx;
`ifdef RR_MUX_LOCK_EN
        if (in_last_i[gnt_idx]) begin
          lock_d = 1'b0;
          ptr_d  = ptr_inc;
        end else begin
          lock_d    = 1'b1;
          lock_ch_d = gnt_idx;
        end
`else
        ptr_d = ptr_inc;
`endif
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
`ifdef RR_MUX_LOCK_EN
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
`ifdef RR_MUX_LOCK_EN
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
`endif
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_sel_o   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
module tb_rr_mux_arb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // N=4 instance
  logic [3:0]  in_valid4;
  logic [31:0] in_data4;
  logic [3:0]  in_ready4;
  logic        mode4;
  logic [3:0]  in_last4;
  logic        out_valid4;
  logic [7:0]  out_data4;
  logic [1:0]  out_sel4;
  logic        out_ready4;

  // N=3 instance
  logic [2:0]  in_valid3;
  logic [23:0] in_data3;
  logic [2:0]  in_ready3;
  logic        mode3;
  logic [2:0]  in_last3;
  logic        out_valid3;
  logic [7:0]  out_data3;
  logic [1:0]  out_sel3;
  logic        out_ready3;

  int n_cmp = 0;
  int n_err = 0;

  rr_mux_arb #(.N(4), .W(8)) u4 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid4), .in_data_i(in_data4), .in_ready_o(in_ready4),
    .mode_i(mode4),
`ifdef RR_MUX_LOCK_EN
    .in_last_i(in_last4),
`endif
    .out_valid_o(out_valid4), .out_data_o(out_data4), .out_sel_o(out_sel4),
    .out_ready_i(out_ready4)
  );

  rr_mux_arb #(.N(3), .W(8)) u3 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid3), .in_data_i(in_data3), .in_ready_o(in_ready3),
    .mode_i(mode3),
`ifdef RR_MUX_LOCK_EN
    .in_last_i(in_last3),
`endif
    .out_valid_o(out_valid3), .out_data_o(out_data3), .out_sel_o(out_sel3),
    .out_ready_i(out_ready3)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out4(input string tag, input logic v, input logic [1:0] s, input logic [7:0] d);
    check_val({tag, ".valid"}, 32'(out_valid4), 32'(v));
    check_val({tag, ".sel"},   32'(out_sel4),   32'(s));
    check_val({tag, ".data"},  32'(out_data4),  32'(d));
  endtask

  task automatic chk_out3(input string tag, input logic v, input logic [1:0] s, input logic [7:0] d);
    check_val({tag, ".valid"}, 32'(out_valid3), 32'(v));
    check_val({tag, ".sel"},   32'(out_sel3),   32'(s));
    check_val({tag, ".data"},  32'(out_data3),  32'(d));
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid4  = '0;
    in_data4   = {8'h13, 8'h12, 8'h11, 8'h10};
    mode4      = 1'b0;
    in_last4   = 4'b1111;
    out_ready4 = 1'b1;
    in_valid3  = '0;
    in_data3   = {8'h22, 8'h21, 8'h20};
    mode3      = 1'b0;
    in_last3   = 3'b111;
    out_ready3 = 1'b1;

    #12 rst_n = 1'b1;

    // idle after reset
    tick();
    chk_out4("idle", 1'b0, 2'd0, 8'h00);
    check_val("idle.rdy", 32'(in_ready4), 32'h0);

    // reset mid-stream with a beat held in the output register
    in_valid4 = 4'b0001;
    #1 check_val("pre_rst.rdy", 32'(in_ready4), 32'h1);
    tick();
    chk_out4("pre_rst", 1'b1, 2'd0, 8'h10);
    rst_n = 1'b0;
    #1;
    chk_out4("in_rst", 1'b0, 2'd0, 8'h00);
    check_val("in_rst.rdy", 32'(in_ready4), 32'h0);
    in_valid4 = '0;
    tick();
    rst_n = 1'b1;
    tick();
    chk_out4("post_rst", 1'b0, 2'd0, 8'h00);
    check_val("post_rst.rdy", 32'(in_ready4), 32'h0);

    // round-robin fairness, ptr restarts at 0 after reset
    in_valid4 = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1 check_val($sformatf("rr%0d.rdy", c), 32'(in_ready4), 32'(4'b0001 << (c % 4)));
      tick();
      chk_out4($sformatf("rr%0d", c), 1'b1, 2'(c % 4), 8'(8'h10 + c % 4));
    end

    // fixed priority
    mode4 = 1'b1;
    in_valid4 = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      #1 check_val($sformatf("fp%0d.rdy", c), 32'(in_ready4), 32'b0010);
      tick();
      chk_out4($sformatf("fp%0d", c), 1'b1, 2'd1, 8'h11);
    end
    in_valid4 = 4'b1000;
    #1 check_val("fp3.rdy", 32'(in_ready4), 32'b1000);
    tick();
    chk_out4("fp3", 1'b1, 2'd3, 8'h13);

    // backpressure: ptr is 0 here; load channel 2 (ptr -> 3)
    mode4 = 1'b0;
    in_valid4 = 4'b0100;
    tick();
    chk_out4("bp_load", 1'b1, 2'd2, 8'h12);
    out_ready4 = 1'b0;
    in_valid4 = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      #1 check_val($sformatf("bp%0d.rdy", c), 32'(in_ready4), 32'h0);
      tick();
      chk_out4($sformatf("bp%0d", c), 1'b1, 2'd2, 8'h12);
    end
    out_ready4 = 1'b1;
    #1 check_val("bp_rel.rdy", 32'(in_ready4), 32'b1000);
    tick();
    chk_out4("bp_rel", 1'b1, 2'd3, 8'h13);
    in_valid4 = '0;
    #1 check_val("drain.rdy", 32'(in_ready4), 32'h0);
    tick();
    chk_out4("drain", 1'b0, 2'd3, 8'h13);

    // N=3 wrap and sparse valid
    in_valid3 = 3'b010;
    #1 check_val("n3a.rdy", 32'(in_ready3), 32'b010);
    tick();
    chk_out3("n3a", 1'b1, 2'd1, 8'h21);
    in_valid3 = 3'b001;
    #1 check_val("n3b.rdy", 32'(in_ready3), 32'b001);
    tick();
    chk_out3("n3b", 1'b1, 2'd0, 8'h20);
    in_valid3 = 3'b101;
    #1 check_val("n3c.rdy", 32'(in_ready3), 32'b100);
    tick();
    chk_out3("n3c", 1'b1, 2'd2, 8'h22);
    #1 check_val("n3d.rdy", 32'(in_ready3), 32'b001);
    tick();
    chk_out3("n3d", 1'b1, 2'd0, 8'h20);
    in_valid3 = '0;
    tick();
    chk_out3("n3e", 1'b0, 2'd0, 8'h20);

`ifdef RR_MUX_LOCK_EN
    // u4 ptr is 0; send a single-beat packet from channel 0 so ptr -> 1
    in_valid4 = 4'b0001;
    in_last4  = 4'b0001;
    tick();
    chk_out4("lk_pre", 1'b1, 2'd0, 8'h10);
    in_valid4 = 4'b0011;
    in_last4  = 4'b0000;
    #1 check_val("lk0.rdy", 32'(in_ready4), 32'b0010);
    tick();
    chk_out4("lk0", 1'b1, 2'd1, 8'h11);
    mode4 = 1'b1;
    #1 check_val("lk1.rdy", 32'(in_ready4), 32'b0010);
    tick();
    chk_out4("lk1", 1'b1, 2'd1, 8'h11);
    mode4 = 1'b0;
    in_last4 = 4'b0010;
    #1 check_val("lk2.rdy", 32'(in_ready4), 32'b0010);
    tick();
    chk_out4("lk2", 1'b1, 2'd1, 8'h11);
    in_last4 = 4'b0001;
    #1 check_val("lk3.rdy", 32'(in_ready4), 32'b0001);
    tick();
    chk_out4("lk3", 1'b1, 2'd0, 8'h10);
    in_valid4 = '0;
    in_last4  = 4'b1111;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
